// File: rtl/arcade_input_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package   : arcade_input_pkg                                               |
// | Purpose   : Shared types and default timing for the coin/start input path. |
// |             Defaults assume a 24.576 MHz system clock.                     |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
package arcade_input_pkg;

  // Coin pulse sequencer states
  typedef enum logic [1:0] {
    CS_IDLE  = 2'd0,
    CS_PULSE = 2'd1,
    CS_GAP   = 2'd2
  } coin_state_t;

  localparam int c_DB_CYC    = 122880;   // 5 ms
  localparam int c_PULSE_CYC = 2457600;  // 100 ms
  localparam int c_GAP_CYC   = 2457600;  // 100 ms
  localparam int c_CNT_W     = 3;

endpackage : arcade_input_pkg
`default_nettype wire

// File: rtl/input_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : input_debounce                                                 |
// | Purpose   : Single-bit debouncer. The output follows the input only after  |
// |             the input has disagreed with it for DB_CYC consecutive clocks. |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module input_debounce #(
  parameter int DB_CYC = 4
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam int CW = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          state_q, state_d;

  // Count consecutive disagreeing samples; flip on the DB_CYC-th one
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    if (din != state_q) begin
      if (cnt_q == CW'(DB_CYC - 1)) begin
        state_d = din;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // State and run-length registers
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout = state_q;

endmodule : input_debounce
`default_nettype wire

// File: rtl/coin_start_conditioner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : coin_start_conditioner                                         |
// | Purpose   : Debounces coin/start requests, queues coin presses as credits  |
// |             and replays them as fixed-width active-low coin pulses with a  |
// |             guaranteed gap. Starts pass through debounced and inverted.    |
// | Options   : COIN_METER_EN - adds coin_total, a 16-bit count of pulses.     |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module coin_start_conditioner
  import arcade_input_pkg::*;
#(
  parameter int DB_CYC    = c_DB_CYC,
  parameter int PULSE_CYC = c_PULSE_CYC,
  parameter int GAP_CYC   = c_GAP_CYC,
  parameter int CNT_W     = c_CNT_W
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             hold,
  input  logic [1:0]       coin_in,
  input  logic [1:0]       start_in,
  output logic             coin_n,
  output logic [1:0]       start_n,
  output logic [CNT_W-1:0] credits_pending,
`ifdef COIN_METER_EN
  output logic [15:0]      coin_total,
`endif
  output logic             overflow
);

  localparam int TMAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int SW   = CNT_W + 2;
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic [3:0] raw_w, db_w;
  assign raw_w = {start_in, coin_in};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_db
      input_debounce #(.DB_CYC(DB_CYC)) u_db (
        .clk_sys (clk_sys),
        .reset   (reset),
        .din     (raw_w[gi]),
        .dout    (db_w[gi])
      );
    end
  endgenerate

  coin_state_t      state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             coin_n_q, coin_n_d;
  logic [1:0]       coin_prev_q;
  logic [1:0]       start_n_q;
  logic [CNT_W-1:0] credits_q, credits_d;
  logic             ovf_q, ovf_d;
  logic             credit_dec;
  logic [1:0]       coin_rise;
  logic [SW-1:0]    sum_w;

  // Edges are ignored while held, but the previous-value register keeps tracking
  assign coin_rise = hold ? 2'b00 : (db_w[1:0] & ~coin_prev_q);

  // Pulse sequencer: next state, timer and coin level
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    coin_n_d   = coin_n_q;
    credit_dec = 1'b0;
    if (hold) begin
      state_d  = CS_IDLE;
      timer_d  = '0;
      coin_n_d = 1'b1;
    end else begin
      case (state_q)
        CS_IDLE: begin
          if (credits_q != '0) begin
            state_d  = CS_PULSE;
            timer_d  = TW'(PULSE_CYC - 1);
            coin_n_d = 1'b0;
          end
        end
        CS_PULSE: begin
          if (timer_q != '0) begin
            timer_d = timer_q - TW'(1);
          end else begin
            state_d    = CS_GAP;
            timer_d    = TW'(GAP_CYC - 1);
            coin_n_d   = 1'b1;
            credit_dec = 1'b1;
          end
        end
        CS_GAP: begin
          if (timer_q != '0) timer_d = timer_q - TW'(1);
          else               state_d = CS_IDLE;
        end
        default: begin
          state_d  = CS_IDLE;
          timer_d  = '0;
          coin_n_d = 1'b1;
        end
      endcase
    end
  end

  // Credit queue: net add/remove, clamped at the queue maximum
  always_comb begin
    sum_w     = SW'(credits_q) + SW'(coin_rise[0]) + SW'(coin_rise[1]) - SW'(credit_dec);
    credits_d = sum_w[CNT_W-1:0];
    ovf_d     = 1'b0;
    if (hold) begin
      credits_d = '0;
    end else if (sum_w > SW'(CMAX)) begin
      credits_d = CMAX;
      ovf_d     = 1'b1;
    end
  end

  // All control registers
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= CS_IDLE;
      timer_q     <= '0;
      coin_n_q    <= 1'b1;
      coin_prev_q <= 2'b00;
      start_n_q   <= 2'b11;
      credits_q   <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      coin_n_q    <= coin_n_d;
      coin_prev_q <= db_w[1:0];
      start_n_q   <= hold ? 2'b11 : ~db_w[3:2];
      credits_q   <= credits_d;
      ovf_q       <= ovf_d;
    end
  end

`ifdef COIN_METER_EN
  logic [15:0] total_q;

  // Lifetime pulse meter, cleared only by reset
  always_ff @(posedge clk_sys) begin
    if (reset)           total_q <= '0;
    else if (credit_dec) total_q <= total_q + 16'd1;
  end

  assign coin_total = total_q;
`endif

  assign coin_n          = coin_n_q;
  assign start_n         = start_n_q;
  assign credits_pending = credits_q;
  assign overflow        = ovf_q;

endmodule : coin_start_conditioner
`default_nettype wire

// File: tb/tb_coin_start_conditioner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : tb_coin_start_conditioner                                      |
// | Purpose   : Directed and randomized bench for coin_start_conditioner,      |
// |             checked against a timestamp-based behavioural model.           |
// | Options   : COIN_METER_EN - also checks coin_total.                        |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module tb_coin_start_conditioner;

  localparam int DB   = 4;
  localparam int PW   = 8;
  localparam int GW   = 6;
  localparam int CW   = 2;
  localparam int MAXC = 3;

  logic          clk_sys = 1'b0;
  logic          reset, hold;
  logic [1:0]    coin_in, start_in;
  logic          coin_n;
  logic [1:0]    start_n;
  logic [CW-1:0] credits_pending;
  logic          overflow;
`ifdef COIN_METER_EN
  logic [15:0]   coin_total;
`endif

  always #5 clk_sys = ~clk_sys;

  coin_start_conditioner #(
    .DB_CYC(DB), .PULSE_CYC(PW), .GAP_CYC(GW), .CNT_W(CW)
  ) dut (
    .clk_sys         (clk_sys),
    .reset           (reset),
    .hold            (hold),
    .coin_in         (coin_in),
    .start_in        (start_in),
    .coin_n          (coin_n),
    .start_n         (start_n),
    .credits_pending (credits_pending),
`ifdef COIN_METER_EN
    .coin_total      (coin_total),
`endif
    .overflow        (overflow)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: coin pulses tracked as edge timestamps
  int       e = 0;
  bit [3:0] m_db;
  int       m_run [4];
  bit [1:0] m_prev;
  int       m_pend;
  bit       m_ovf;
  int       pstart;      // edge at which current pulse began, -1 if none
  int       idle_from;   // earliest edge a new pulse may begin
  bit [1:0] m_start_n;
  bit       m_coin_n;
  int       m_total;
  int       m_ovf_cnt;

  task automatic model_edge(input bit [3:0] raw, input bit h, input bit r);
    bit [3:0] old_db;
    bit [1:0] rise;
    int       n, dec;
    e++;
    if (r) begin
      m_db = '0; m_prev = '0; m_pend = 0; m_ovf = 0; pstart = -1;
      idle_from = e + 1; m_start_n = 2'b11; m_coin_n = 1'b1; m_total = 0;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
      return;
    end
    old_db    = m_db;
    rise      = old_db[1:0] & ~m_prev;
    m_prev    = old_db[1:0];
    m_start_n = h ? 2'b11 : ~old_db[3:2];
    m_ovf     = 0;
    if (h) begin
      m_pend = 0; pstart = -1; idle_from = e + 1;
    end else begin
      dec = 0;
      if (pstart >= 0 && e == pstart + PW) begin
        dec = 1; pstart = -1; idle_from = e + GW + 1;
        m_total = (m_total + 1) % 65536;
      end else if (pstart < 0 && e >= idle_from && m_pend != 0) begin
        pstart = e;
      end
      n = m_pend + int'(rise[0]) + int'(rise[1]) - dec;
      if (n > MAXC) begin n = MAXC; m_ovf = 1; m_ovf_cnt++; end
      m_pend = n;
    end
    m_coin_n = (pstart < 0);
    for (int i = 0; i < 4; i++) begin
      if (raw[i] != m_db[i]) begin
        m_run[i]++;
        if (m_run[i] == DB) begin m_db[i] = raw[i]; m_run[i] = 0; end
      end else begin
        m_run[i] = 0;
      end
    end
  endtask

  // Pulse-shape monitor on the DUT output
  int lowrun = 0, highrun = 0, last_low = 0, last_high = 0, low_total = 0;
  int dut_ovf_cnt = 0;
  bit seen_pulse = 0;

  task automatic step(input logic [1:0] c, input logic [1:0] s, input logic h, input logic r);
    coin_in = c; start_in = s; hold = h; reset = r;
    model_edge({s, c}, h, r);
    @(negedge clk_sys);
    check("coin_n",   32'(coin_n),          32'(m_coin_n));
    check("start_n",  32'(start_n),         32'(m_start_n));
    check("pending",  32'(credits_pending), 32'(m_pend));
    check("overflow", 32'(overflow),        32'(m_ovf));
`ifdef COIN_METER_EN
    check("coin_total", 32'(coin_total),    32'(m_total));
`endif
    if (overflow === 1'b1) dut_ovf_cnt++;
    if (coin_n === 1'b0) begin
      if (lowrun == 0 && seen_pulse) last_high = highrun;
      lowrun++; low_total++;
    end else begin
      if (lowrun > 0) begin last_low = lowrun; seen_pulse = 1; highrun = 0; end
      lowrun = 0; highrun++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'b00, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic clear_mon();
    lowrun = 0; highrun = 0; last_low = 0; last_high = 0; low_total = 0;
    seen_pulse = 0; dut_ovf_cnt = 0; m_ovf_cnt = 0;
  endtask

  initial begin
    int waited;
    coin_in = '0; start_in = '0; hold = 1'b0; reset = 1'b1;
    step(2'b00, 2'b00, 1'b0, 1'b1);
    step(2'b00, 2'b00, 1'b0, 1'b1);
    idle(3);

    // Single coin1 held 10 clocks: fall 6 edges after rise, 8 low
    clear_mon();
    for (int i = 0; i < 10; i++) begin
      step(2'b01, 2'b00, 1'b0, 1'b0);
      if (i == 4) check("single_not_yet_low", 32'(coin_n), 32'd1);
      if (i == 5) check("single_low_at_6", 32'(coin_n), 32'd0);
    end
    idle(20);
    check("single_low_len", 32'(last_low), 32'(PW));
    check("single_ovf", 32'(dut_ovf_cnt), 32'd0);

    // Three-clock glitch must be rejected
    clear_mon();
    for (int i = 0; i < 3; i++) step(2'b01, 2'b00, 1'b0, 1'b0);
    idle(12);
    check("glitch_low", 32'(low_total), 32'd0);

    // Both coins together: two pulses, 7 high clocks between
    clear_mon();
    for (int i = 0; i < 6; i++) step(2'b11, 2'b00, 1'b0, 1'b0);
    check("dual_pending", 32'(credits_pending), 32'd2);
    idle(40);
    check("dual_low_len", 32'(last_low), 32'(PW));
    check("dual_gap_len", 32'(last_high), 32'(GW + 1));
    check("dual_low_total", 32'(low_total), 32'(2 * PW));

    // Repeated double presses drive the queue into saturation
    clear_mon();
    for (int p = 0; p < 5; p++) begin
      for (int i = 0; i < 5; i++) step(2'b11, 2'b00, 1'b0, 1'b0);
      idle(5);
    end
    check("sat_ovf_count", 32'(dut_ovf_cnt), 32'(m_ovf_cnt));
    check("sat_ovf_seen", 32'(m_ovf_cnt > 0), 32'd1);
    idle(150);

    // Hold three clocks into a pulse, starts held down throughout
    clear_mon();
    for (int i = 0; i < 6; i++) step(2'b01, 2'b11, 1'b0, 1'b0);
    waited = 0;
    while (coin_n !== 1'b0 && waited < 20) begin
      step(2'b00, 2'b11, 1'b0, 1'b0); waited++;
    end
    check("hold_pulse_started", 32'(coin_n), 32'd0);
    for (int i = 0; i < 3; i++) step(2'b00, 2'b11, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(2'b00, 2'b11, 1'b1, 1'b0);
      check("hold_coin_n", 32'(coin_n), 32'd1);
      check("hold_start_n", 32'(start_n), 32'd3);
    end
    low_total = 0;
    for (int i = 0; i < 30; i++) step(2'b00, 2'b11, 1'b0, 1'b0);
    check("hold_no_pulse_after", 32'(low_total), 32'd0);
    idle(10);

`ifdef COIN_METER_EN
    step(2'b00, 2'b00, 1'b0, 1'b1);
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 6; i++) step(2'b01, 2'b00, 1'b0, 1'b0);
      idle(25);
    end
    step(2'b00, 2'b00, 1'b1, 1'b0);
    step(2'b00, 2'b00, 1'b0, 1'b0);
    check("meter_three", 32'(coin_total), 32'd3);
    step(2'b00, 2'b00, 1'b0, 1'b1);
    check("meter_reset", 32'(coin_total), 32'd0);
`endif

    // Randomized segments with occasional hold and reset
    for (int seg = 0; seg < 200; seg++) begin
      logic [1:0] c, s;
      logic       h, r;
      int         len;
      c   = ($urandom_range(0, 2) == 0) ? 2'b00 : 2'($urandom_range(0, 3));
      s   = 2'($urandom_range(0, 3));
      h   = ($urandom_range(0, 14) == 0);
      r   = ($urandom_range(0, 49) == 0);
      len = $urandom_range(1, 14);
      for (int i = 0; i < len; i++) step(c, s, h, (i == 0) ? r : 1'b0);
    end
    idle(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_coin_start_conditioner
`default_nettype wire
